sample_buffer_ctrl: RTL
=======================

SAMPLE_BUFFER_CTRL -- requirements
Module: sample_buffer_ctrl

Interface
REQ-001 Parameter N, default 100, buffer depth in words (N >= 2).
REQ-002 Parameter W, default 64, sample width in bits.
REQ-003 Derived constant CW = $clog2(N+1), width of count.
REQ-004 clock  input  1  rising-edge clock; single clock domain.
REQ-005 reset_n  input  1  asynchronous assert, active-low reset.
REQ-006 start  input  1  one-cycle pulse that opens a new load.
REQ-007 in_valid  input  1  source sample valid.
REQ-008 in_data  input  W  source sample.
REQ-009 in_last  input  1  source end-of-stream marker; qualified by in_valid.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 drain  input  1  one-cycle pulse that starts readout of the stored samples.
REQ-012 out_valid  output  1  out_data holds a stored sample.
REQ-013 out_data  output  W  stored sample, in write order.
REQ-014 out_last  output  1  marks the final stored sample; qualified by out_valid.
REQ-015 out_ready  input  1  consumer accepts the sample.
REQ-016 count  output  CW  number of samples stored in the current load.
REQ-017 done  output  1  high while state is READY.
REQ-018 overflow  output  1  sticky; buffer filled before the source sent in_last.

Function
REQ-019 States are IDLE, LOAD, READY and DRAIN.
REQ-020 IDLE: in_ready=0, out_valid=0; start -> LOAD, with count, write pointer and overflow all cleared.
REQ-021 LOAD: in_ready=1; a beat is accepted when in_valid and in_ready are both 1; the accepted beat writes in_data to address count; count then increments.
REQ-022 The in_last beat is stored as data; accepting it -> READY on the next edge.
REQ-023 An accepted beat that brings count to N -> READY; if in_last=0 on that beat, overflow is set to 1.
REQ-024 in_ready=0 in IDLE, READY and DRAIN; no write occurs in those states.
REQ-025 READY: done=1 and count stays stable; drain -> DRAIN; start -> LOAD (restart, overwrites the buffer); if start and drain are both high, start wins.
REQ-026 start is ignored in LOAD and DRAIN; drain is ignored outside READY.
REQ-027 DRAIN: out_valid first rises on the second rising edge after the edge on which drain was sampled (RAM read latency of 1).
REQ-028 While out_valid=1 and out_ready=0, out_data, out_last and out_valid are held stable.
REQ-029 With out_ready held at 1, the block delivers one sample per cycle with no bubbles; a prefetch register is required.
REQ-030 out_last=1 exactly when the sample presented is at index count-1.
REQ-031 On the out_last handshake the state goes to IDLE and out_valid drops on the next edge.
REQ-032 count is not cleared by DRAIN; it holds until the next start.
REQ-033 count never exceeds N; the write pointer never wraps.

Reset
REQ-034 reset_n low forces IDLE with in_ready=0, out_valid=0, out_data=0, out_last=0, count=0, done=0, overflow=0 and the read and write pointers at 0, all with no clock required.
REQ-035 Reset in mid-LOAD or mid-DRAIN aborts the operation; memory contents are not cleared; the block then waits for start.
REQ-036 Reset deassertion is assumed synchronized to clock upstream.

Structure
REQ-037 Shared package sample_buffer_pkg holds the state enum (IDLE, LOAD, READY, DRAIN) and the constants N_DEFAULT=100 and W_DEFAULT=64.
REQ-038 Storage lives in sub-module sample_ram: N x W, one write port, one synchronous read port, no reset.
REQ-039 The FSM, pointers and prefetch register are in sample_buffer_ctrl.

Verification
REQ-040 Stimulus: start, then 5 beats 1..5 with in_last on 5, then drain with out_ready=1. Required: count=5, done=1, overflow=0; outputs 1..5 back-to-back, out_last on 5, then IDLE.
REQ-041 Stimulus: N=100, 100 beats with in_last=0. Required: READY after the 100th beat, overflow=1, in_ready=0; a 101st in_valid is not accepted; count=100.
REQ-042 Stimulus: drain readout with out_ready toggling 1,0,0,1 per cycle. Required: each sample is held while stalled, no sample is skipped or duplicated, and the order is preserved.
REQ-043 Stimulus: in_valid gaps during LOAD, and start and drain pulsed during LOAD. Required: only valid beats are stored and both pulses are ignored.
REQ-044 Stimulus: start and drain asserted together in READY. Required: LOAD is entered and count=0.
REQ-045 Stimulus: reset_n pulsed low mid-DRAIN after 2 of 5 samples. Required: immediate IDLE and all outputs 0; a new start/load/drain then works normally.

Source files
------------

// File: rtl/sample_buffer_pkg.sv
// Shared definitions for the sample buffer controller.
//   state_e   : controller states IDLE / LOAD / READY / DRAIN
//   N_DEFAULT : default buffer depth in words
//   W_DEFAULT : default sample width in bits
//   addr_w()  : RAM address width for a given depth (at least 1 bit)
package sample_buffer_pkg;

  localparam int N_DEFAULT = 100;
  localparam int W_DEFAULT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2,
    DRAIN = 2'd3
  } state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sample_buffer_ram.sv
// Sample storage: N words of W bits, one write port and one synchronous
// read port (read data appears one clock after rd_en). No reset; contents
// survive controller resets.
//   clock   : rising-edge clock
//   wr_en   : write strobe, wr_addr / wr_data written on the edge
//   rd_en   : read strobe, mem[rd_addr] lands on rd_data after the edge
//   rd_data : registered read data
module sample_ram
  import sample_buffer_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int W  = W_DEFAULT,
  parameter int AW = addr_w(N)
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sample_buffer_ctrl.sv
// Sample buffer controller: captures a stream of up to N samples into
// sample_ram, then plays them back in write order on a valid/ready port.
//   clock, reset_n        : clock and asynchronous active-low reset
//   start                 : pulse, opens a new load (IDLE or READY)
//   in_valid/in_data/in_last/in_ready : source stream
//   drain                 : pulse, starts readout (READY only)
//   out_valid/out_data/out_last/out_ready : readout stream
//   count                 : samples stored in the current load
//   done                  : high while in READY
//   overflow              : sticky, buffer filled before in_last arrived
// Readout path: RAM read (vld_p0) feeds the output register, with a one
// entry skid register (_p1) so a full-rate stream survives out_ready stalls.
module sample_buffer_ctrl
  import sample_buffer_pkg::*;
#(
  parameter  int N  = N_DEFAULT,
  parameter  int W  = W_DEFAULT,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  output logic          in_ready,
  input  logic          drain,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          done,
  output logic          overflow
);

  localparam int            AW       = addr_w(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e        state, state_nxt;
  logic          accept, full_beat, pop, issue;
  logic          load_clr, drain_go, skid_load;
  logic [1:0]    occ_sum;
  logic [CW-1:0] rd_ptr;
  logic          vld_p0, last_p0;
  logic [W-1:0]  rd_data_p0;
  logic          skid_vld_p1, skid_last_p1;
  logic [W-1:0]  skid_data_p1;

  assign in_ready  = (state == LOAD);
  assign done      = (state == READY);
  assign accept    = in_valid & in_ready;
  // The count is also the write pointer, so it never exceeds N.
  assign full_beat = accept && (count == CNT_LAST);
  assign pop       = out_valid & out_ready;
  assign load_clr  = start && ((state == IDLE) || (state == READY));
  assign drain_go  = drain && !start && (state == READY);

  // Reads in flight plus samples held must never exceed the two
  // holding registers (output + skid); a pop this cycle frees one slot.
  assign occ_sum   = 2'(out_valid) + 2'(skid_vld_p1) + 2'(vld_p0);
  assign issue     = (state == DRAIN) && (rd_ptr < count) &&
                     (occ_sum < (pop ? 2'd3 : 2'd2));

  // An arriving RAM word parks in the skid register when the output
  // register stays occupied, or when the skid moves into the output.
  assign skid_load = vld_p0 && (skid_vld_p1 || (out_valid && !pop));

  sample_ram #(.N(N), .W(W), .AW(AW)) u_ram (
    .clock   (clock),
    .wr_en   (accept),
    .wr_addr (count[AW-1:0]),
    .wr_data (in_data),
    .rd_en   (issue),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_data_p0)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (accept && (in_last || full_beat)) state_nxt = READY;
      READY:   if (start) state_nxt = LOAD;
               else if (drain) state_nxt = DRAIN;
      DRAIN:   if (pop && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (load_clr) begin
      count    <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      count <= count + CNT_ONE;
      if (full_beat && !in_last) overflow <= 1'b1;
    end
  end

  // Stage p0: RAM read issue, data lands one edge later
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr  <= '0;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      if (drain_go)   rd_ptr <= '0;
      else if (issue) rd_ptr <= rd_ptr + CNT_ONE;
      vld_p0  <= issue;
      last_p0 <= issue && (rd_ptr == count - CNT_ONE);
    end
  end

  // Stage p1: output register and skid register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      skid_vld_p1  <= 1'b0;
      skid_last_p1 <= 1'b0;
    end else if (state != DRAIN) begin
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      skid_vld_p1  <= 1'b0;
      skid_last_p1 <= 1'b0;
    end else if (!out_valid || pop) begin
      if (skid_vld_p1) begin
        out_valid    <= 1'b1;
        out_last     <= skid_last_p1;
        out_data     <= skid_data_p1;
        skid_vld_p1  <= vld_p0;
        skid_last_p1 <= last_p0;
      end else begin
        out_valid <= vld_p0;
        out_last  <= vld_p0 && last_p0;
        if (vld_p0) out_data <= rd_data_p0;
      end
    end else if (vld_p0) begin
      skid_vld_p1  <= 1'b1;
      skid_last_p1 <= last_p0;
    end
  end

  always_ff @(posedge clock) begin
    if (skid_load) skid_data_p1 <= rd_data_p0;
  end

endmodule
